// File: rtl/step_pkg.sv
// ----------------------------------------------------------------------------
// step_pkg
// Shared types and default widths for the step scheduler.
//   step_state_t : burst sequencer states
//   DEF_*        : default parameter values for step_scheduler
// ----------------------------------------------------------------------------
package step_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } step_state_t;

    localparam int DEF_REQUESTERS  = 4;
    localparam int DEF_COUNT_WIDTH = 8;
    localparam int DEF_GAP_WIDTH   = 4;

endpackage

// File: rtl/step_rr_arbiter.sv
// ----------------------------------------------------------------------------
// step_rr_arbiter
// Combinational round-robin pick. Scans the request vector starting at
// i_pointer and wrapping, and returns the first requester found.
//   i_req     : request vector
//   i_pointer : index with the highest priority this round
//   o_winner  : one-hot winner, 0 when nobody requests
//   o_any     : at least one request is present
// ----------------------------------------------------------------------------
module step_rr_arbiter
    import step_pkg::*;
#(
    parameter  int REQUESTERS = DEF_REQUESTERS,
    localparam int PW         = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic [REQUESTERS-1:0] i_req,
    input  logic [PW-1:0]         i_pointer,
    output logic [REQUESTERS-1:0] o_winner,
    output logic                  o_any
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            w_idx = PW'((int'(i_pointer) + i) % REQUESTERS);
            if (!w_found && i_req[w_idx]) begin
                o_winner[w_idx] = 1'b1;
                w_found         = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/step_scheduler.sv
// ----------------------------------------------------------------------------
// step_scheduler
// Shares one step-pulse generator among REQUESTERS clients. A round-robin
// arbiter picks a client, whose burst of req_count step strobes is emitted
// with gap idle cycles between strobes.
//   | state | meaning                                         |
//   | IDLE  | no owner, arbitrating on req                     |
//   | STEP  | one-cycle step strobe for the owner              |
//   | GAP   | idle cycles between two strobes                  |
//   | DONE  | one-cycle completion pulse to the owner          |
// Ports:
//   clock, reset_n : clock and async active-low reset
//   req, req_count : per-client request level and burst length
//   gap, abort     : inter-step gap and early termination
//   grant, step, step_index, done, aborted, busy : registered-state outputs
// ----------------------------------------------------------------------------
module step_scheduler
    import step_pkg::*;
#(
    parameter  int REQUESTERS  = DEF_REQUESTERS,
    parameter  int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter  int GAP_WIDTH   = DEF_GAP_WIDTH,
    localparam int PW          = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [REQUESTERS-1:0]             req,
    input  logic [REQUESTERS*COUNT_WIDTH-1:0] req_count,
    input  logic [GAP_WIDTH-1:0]              gap,
    input  logic                              abort,
    output logic [REQUESTERS-1:0]             grant,
    output logic                              step,
    output logic [COUNT_WIDTH-1:0]            step_index,
    output logic [REQUESTERS-1:0]             done,
    output logic                              aborted,
    output logic                              busy
);

    step_state_t            r_state;
    step_state_t            w_next;
    logic [REQUESTERS-1:0]  r_owner;
    logic [PW-1:0]          r_owner_idx;
    logic [PW-1:0]          r_start;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic [COUNT_WIDTH-1:0] r_index;
    logic [GAP_WIDTH-1:0]   r_gap;
    logic [GAP_WIDTH-1:0]   r_gap_cnt;
    logic                   r_aborted;

    logic [REQUESTERS-1:0]  w_winner;
    logic                   w_any;
    logic [PW-1:0]          w_win_idx;
    logic [COUNT_WIDTH-1:0] w_win_count;

    step_rr_arbiter #(.REQUESTERS(REQUESTERS)) u_arb (
        .i_req     (req),
        .i_pointer (r_start),
        .o_winner  (w_winner),
        .o_any     (w_any)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (w_winner[i]) w_win_idx = PW'(i);
        end
    end

    assign w_win_count = req_count[int'(w_win_idx)*COUNT_WIDTH +: COUNT_WIDTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        busy       = (r_state != IDLE);
        grant      = busy ? r_owner : '0;
        step       = (r_state == STEP);
        step_index = busy ? r_index : '0;
        done       = (r_state == DONE) ? r_owner : '0;
        aborted    = (r_state == DONE) && r_aborted;
        case (r_state)
            IDLE: if (w_any) w_next = (w_win_count != '0) ? STEP : DONE;
            STEP: begin
                if (r_remaining == COUNT_WIDTH'(1) || abort) w_next = DONE;
                else if (r_gap == '0)                        w_next = STEP;
                else                                         w_next = GAP;
            end
            GAP: begin
                if (abort)                                w_next = DONE;
                else if (r_gap_cnt == GAP_WIDTH'(1))      w_next = STEP;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_owner     <= '0;
            r_owner_idx <= '0;
            r_start     <= '0;
            r_remaining <= '0;
            r_index     <= '0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            r_aborted   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_owner     <= w_winner;
                    r_owner_idx <= w_win_idx;
                    r_remaining <= w_win_count;
                    r_index     <= '0;
                    r_gap       <= gap;
                    r_aborted   <= 1'b0;
                end
                STEP: begin
                    r_remaining <= r_remaining - COUNT_WIDTH'(1);
                    // Index is held on the last strobe so it never reaches N.
                    if (w_next == DONE) r_aborted <= (r_remaining != COUNT_WIDTH'(1));
                    else                r_index   <= r_index + COUNT_WIDTH'(1);
                    if (w_next == GAP)  r_gap_cnt <= r_gap;
                end
                GAP: begin
                    r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
                    if (w_next == DONE) r_aborted <= 1'b1;
                end
                DONE: begin
                    // Owner drops to lowest priority for the next round.
                    r_start <= (r_owner_idx == PW'(REQUESTERS-1)) ? '0
                                                                  : r_owner_idx + PW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_step_scheduler.sv
module tb_step_scheduler;

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b0;
    logic [3:0]  req       = '0;
    logic [31:0] req_count = '0;
    logic [3:0]  gap       = '0;
    logic        abort     = 1'b0;
    logic [3:0]  grant;
    logic        step;
    logic [7:0]  step_index;
    logic [3:0]  done;
    logic        aborted;
    logic        busy;

    step_scheduler #(.REQUESTERS(4), .COUNT_WIDTH(8), .GAP_WIDTH(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .req_count  (req_count),
        .gap        (gap),
        .abort      (abort),
        .grant      (grant),
        .step       (step),
        .step_index (step_index),
        .done       (done),
        .aborted    (aborted),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit         is_done;
        logic [3:0] grant;
        logic [7:0] idx;
        logic       ab;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];

    // Expected step/done events of one burst started at edge k.
    task automatic push_burst(input int owner, input int k, input int n,
                              input int g, input int n_abort);
        ev_t        e;
        logic [3:0] one;
        int         s;
        one = 4'b0001;
        e.grant = one << owner;
        e.ab    = 1'b0;
        e.idx   = '0;
        if (n == 0) begin
            e.is_done = 1'b1;
            e.cyc     = k + 1;
            exp_q.push_back(e);
            return;
        end
        s = (n_abort > 0) ? n_abort : n;
        for (int i = 0; i < s; i++) begin
            e.is_done = 1'b0;
            e.idx     = 8'(i);
            e.cyc     = k + 1 + i * (g + 1);
            exp_q.push_back(e);
        end
        e.is_done = 1'b1;
        e.idx     = '0;
        e.ab      = (n_abort > 0);
        e.cyc     = k + 2 + (s - 1) * (g + 1);
        exp_q.push_back(e);
    endtask

    // Scoreboard: every strobe or completion must match the next expectation.
    always @(negedge clock) begin
        ev_t e;
        if (reset_n && (step || done != 4'b0)) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d step=%b done=%b grant=%b", cyc, step, done, grant);
            end else begin
                e = exp_q.pop_front();
                if (!e.is_done) begin
                    if ({step, done, grant, step_index, aborted} !== {1'b1, 4'b0, e.grant, e.idx, 1'b0}
                        || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL step_event got cyc=%0d step=%b done=%b grant=%b idx=%0d ab=%b want cyc=%0d grant=%b idx=%0d",
                                 cyc, step, done, grant, step_index, aborted, e.cyc, e.grant, e.idx);
                    end
                end else begin
                    if ({step, done, grant, aborted} !== {1'b0, e.grant, e.grant, e.ab} || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL done_event got cyc=%0d step=%b done=%b grant=%b ab=%b want cyc=%0d grant=%b ab=%b",
                                 cyc, step, done, grant, aborted, e.cyc, e.grant, e.ab);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int target);
        int t;
        t = 0;
        while (cyc != target && t < 2000) begin
            @(negedge clock);
            t++;
        end
        if (cyc != target) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_timeout cyc=%0d want=%0d", cyc, target);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        n_tests++;
        if ({grant, step, step_index, done, aborted, busy} !== 19'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got grant=%b step=%b idx=%0d done=%b ab=%b busy=%b want all 0",
                     grant, step, step_index, done, aborted, busy);
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_tests++;
        if (busy !== 1'b0 || grant !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_idle got busy=%b grant=%b want 0", busy, grant);
        end
    endtask

    task automatic test_single_gap0();
        int k;
        @(negedge clock);
        k = cyc;
        req_count[7:0] = 8'd3;
        gap = 4'd0;
        req = 4'b0001;
        push_burst(0, k, 3, 0, 0);
        wait_cyc(k + 1);
        n_tests++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant_first got grant=%b busy=%b want 0001 1", grant, busy);
        end
        wait_cyc(k + 4);
        n_tests++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_grant_done got %b want 0001", grant);
        end
        wait_cyc(k + 5);
        req = 4'b0;
        n_tests++;
        if (grant !== 4'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle got grant=%b busy=%b want 0 0", grant, busy);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_drain got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_gap();
        int k;
        @(negedge clock);
        k = cyc;
        req_count[15:8] = 8'd2;
        gap = 4'd2;
        req = 4'b0010;
        push_burst(1, k, 2, 2, 0);
        wait_cyc(k + 2);
        n_tests++;
        if (step !== 1'b0 || grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL gap_cycle1 got step=%b grant=%b want 0 0010", step, grant);
        end
        wait_cyc(k + 3);
        n_tests++;
        if (step !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_cycle2 got step=%b want 0", step);
        end
        wait_cyc(k + 6);
        req = 4'b0;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL gap_drain got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_zero_count();
        int k;
        @(negedge clock);
        k = cyc;
        req_count[23:16] = 8'd0;
        gap = 4'd0;
        req = 4'b0100;
        push_burst(2, k, 0, 0, 0);
        wait_cyc(k + 1);
        n_tests++;
        if (busy !== 1'b1 || grant !== 4'b0100 || step !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done_cycle got busy=%b grant=%b step=%b want 1 0100 0", busy, grant, step);
        end
        wait_cyc(k + 2);
        req = 4'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_busy_len got busy=%b want 0", busy);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL zero_drain got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_abort();
        int k;
        @(negedge clock);
        k = cyc;
        req_count[31:24] = 8'd10;
        req_count[7:0]   = 8'd1;
        gap = 4'd1;
        req = 4'b1001;
        push_burst(3, k, 10, 1, 3);
        push_burst(0, k + 7, 1, 1, 0);
        wait_cyc(k + 5);
        abort = 1'b1;
        n_tests++;
        if (step !== 1'b1 || step_index !== 8'd2) begin
            n_fail++;
            $display("FAIL abort_third_step got step=%b idx=%0d want 1 2", step, step_index);
        end
        wait_cyc(k + 6);
        abort = 1'b0;
        wait_cyc(k + 7);
        req = 4'b0001;
        n_tests++;
        if (busy !== 1'b0 || grant !== 4'b0) begin
            n_fail++;
            $display("FAIL abort_idle_gap got busy=%b grant=%b want 0 0", busy, grant);
        end
        wait_cyc(k + 10);
        req = 4'b0;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL abort_drain got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_burst();
        int  k;
        ev_t e;
        @(negedge clock);
        k = cyc;
        req_count[15:8] = 8'd10;
        gap = 4'd0;
        req = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            e.is_done = 1'b0;
            e.grant   = 4'b0010;
            e.idx     = 8'(i);
            e.ab      = 1'b0;
            e.cyc     = k + 1 + i;
            exp_q.push_back(e);
        end
        wait_cyc(k + 2);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        req = 4'b0;
        #1;
        n_tests++;
        if ({grant, step, step_index, done, aborted, busy} !== 19'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got grant=%b step=%b idx=%0d done=%b busy=%b want all 0",
                     grant, step, step_index, done, busy);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_tests++;
            if (done !== 4'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_nodone got done=%b busy=%b want 0 0", done, busy);
            end
        end
        reset_n = 1'b1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_drain got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clock);
        k = cyc;
        req_count[7:0]   = 8'd1;
        req_count[31:24] = 8'd1;
        req = 4'b1001;
        push_burst(0, k, 1, 0, 0);
        push_burst(3, k + 3, 1, 0, 0);
        wait_cyc(k + 3);
        req = 4'b1000;
        wait_cyc(k + 6);
        req = 4'b0;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_prio_drain got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_round_robin();
        int k;
        @(negedge clock);
        k = cyc;
        req_count = {8'd1, 8'd1, 8'd1, 8'd1};
        gap = 4'd0;
        req = 4'b1111;
        for (int j = 0; j < 5; j++) push_burst(j % 4, k + 3 * j, 1, 0, 0);
        for (int j = 0; j < 4; j++) begin
            wait_cyc(k + 3 + 3 * j);
            n_tests++;
            if (busy !== 1'b0 || grant !== 4'b0) begin
                n_fail++;
                $display("FAIL rr_idle_between got busy=%b grant=%b want 0 0 (burst %0d)", busy, grant, j);
            end
        end
        wait_cyc(k + 15);
        req = 4'b0;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rr_drain got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_gap0();
        test_gap();
        test_zero_count();
        test_abort();
        test_reset_mid_burst();
        test_round_robin();
        repeat (4) @(negedge clock);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_drain got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
